epg_tx_lanes: RTL
=================

Name: epg_tx_lanes

Overview:
Second-generation IPv4-style packet generator transmitter.
- Header fields, options and payload words are loaded over a CTRL/DIN bus; SEND then serialises the packet out on a LANES-wide bus.
- Adds over the first generation: parametrised lane width and buffer depths, auto-computed IHL and total length, an optional header checksum, and framing strobes (valid/SOP/EOP).
- Sits between a host load interface and the matching receiver.

Parameters:
LANES, 1, serial output width in bits; one of 1,2,4,8,16,32.
OPT_DEPTH, 4, option word buffer depth; 1..10, so IHL never exceeds 15.
DATA_DEPTH, 8, payload word buffer depth; 1..256.
PROTO, 8'h11, protocol byte inserted in header word 2.
GAP_CYCLES, 2, idle cycles after EOP before BUSY drops; 0..15.

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
EN  in  1  global enable; 0 freezes all state (stall)
DIN  in  32  load data
CTRL  in  3  load select: 0 nop, 1 TOS[7:0], 2 ID[15:0], 3 TTL[7:0], 4 SA, 5 DA, 6 push option, 7 push payload
SEND  in  1  start request, sampled in IDLE
BUSY  out  1  packet in progress (CALC..GAP)
OFULL  out  1  option buffer holds OPT_DEPTH words
DFULL  out  1  payload buffer holds DATA_DEPTH words
OP_TX  out  LANES  serial data, MSB-first within each 32-bit word
OP_VALID  out  1  OP_TX carries packet bits this cycle
OP_SOP  out  1  first beat of packet
OP_EOP  out  1  last beat of packet
INDICATOR  out  32  {12'b0, IHL[3:0], TOTAL_LEN[15:0]}, live from current buffer counts

Behaviour:
- Reset: all outputs 0; header regs 0; buffer counts 0; FSM in IDLE. RST overrides EN. RST mid-packet aborts with no EOP.
- EN=0: no state, counter or buffer changes. Outputs hold their values, except OP_VALID/SOP/EOP, which are forced 0.
- Loads are accepted only in IDLE with EN=1; otherwise ignored.
- Pushes to a full buffer are dropped; the count saturates.
- OFULL/DFULL are registered and update in the cycle after the push.
- IHL = 5 + opt_cnt. TOTAL_LEN = 4*(IHL + data_cnt), 16 bits.
- Header words in order:
  - {4'h4, IHL, TOS, TOTAL_LEN}
  - {ID, 16'h0000}
  - {TTL, PROTO, CKSUM}
  - SA
  - DA
  - then option words, then payload words, in push order.
- FSM: IDLE -> CALC -> HDR -> OPT -> DATA -> GAP -> IDLE.
  - IDLE: SEND=1 with EN=1 moves to CALC. SEND while not IDLE is ignored.
  - CALC: lasts opt_cnt+1 cycles.
    - Cycle 0 sums the fixed header 16-bit halves.
    - Each later cycle adds both halves of one option word.
    - All adds use 16-bit ones'-complement end-around carry.
    - CKSUM = ~sum.
  - HDR/OPT/DATA: each word takes 32/LANES beats.
    - OPT is skipped if opt_cnt=0; DATA is skipped if data_cnt=0.
    - OP_VALID=1 on every beat; SOP on the first HDR beat; EOP on the last beat of the last word.
  - GAP: GAP_CYCLES cycles, then IDLE. On the IDLE transition, option and payload counts clear; header regs are kept.
- Latency: SEND accepted in cycle t gives first OP_VALID in cycle t+opt_cnt+2.
- BUSY is 1 from cycle t+1 until the last GAP cycle inclusive.
- Packet length in beats = (IHL + data_cnt)*32/LANES.

Optional Feature:
EPG_CHECKSUM_EN
- Defined: CALC state is present and CKSUM is computed as above.
- Undefined: no CALC state, IDLE goes straight to HDR, CKSUM field = 16'h0000, first OP_VALID at t+1.

Decomposition:
- Package epg_pkg holds:
  - ctrl_e enum (NOP, TOS, ID, TTL, SA, DA, OPT, DTA)
  - state_e enum
  - IPV4_VER = 4'h4 and MIN_IHL = 5 constants
  - function oc_add16 (ones'-complement add)
- One sub-module, epg_word_buf: parametrised-depth word buffer with push, indexed read, count, full and clear. Instantiated twice (options, payload).

Test Plan:
- Checksum, PROTO default, LANES=32:
  - Stimulus: TOS=00, ID=0000, TTL=40, SA=c0a80001, DA=c0a800c7, no options, no payload, SEND.
  - Required: 5 beats: 45000014, 00000000, 401 1F8C0 (i.e. 4011F8C0), c0a80001, c0a800c7. SOP on beat 1, EOP on beat 5, INDICATOR=00050014.
- LANES=1, 2 options, 3 payload words:
  - Required: 320 beats, IHL=7, TOTAL_LEN=0x0028.
  - First OP_VALID exactly 4 cycles after the SEND cycle; BUSY drops GAP_CYCLES after EOP.
- Overflow, OPT_DEPTH=4:
  - Stimulus: push 6 options.
  - Required: OFULL=1 after the 4th push; IHL=9; only the first 4 option values are transmitted.
- Stall:
  - Stimulus: EN=0 for 7 cycles mid-DATA (LANES=8).
  - Required: OP_VALID=0 during the stall; the bit stream resumes unbroken; beat count unchanged.
- Reset mid-packet:
  - Stimulus: RST during OPT.
  - Required: next cycle all outputs 0, state IDLE, counts 0.
  - A later SEND with no loads yields a 5-word header with TOTAL_LEN=0x0014.
- Ignored SEND/loads while BUSY:
  - Stimulus: CTRL=7 pushes and a second SEND mid-packet.
  - Required: no effect on the packet in flight or on counts.

Source files
------------

// File: rtl/epg_pkg.sv
// Shared types, constants and the ones'-complement adder for the packet generator.
package epg_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        TOS = 3'd1,
        ID  = 3'd2,
        TTL = 3'd3,
        SA  = 3'd4,
        DA  = 3'd5,
        OPT = 3'd6,
        DTA = 3'd7
    } ctrl_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_HDR  = 3'd2,
        S_OPT  = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5
    } state_e;

    localparam logic [3:0] IPV4_VER = 4'h4;
    localparam logic [3:0] MIN_IHL  = 4'd5;

    // 16-bit add with the carry folded back into bit 0
    function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/epg_word_buf.sv
// Word buffer for option or payload words: push appends, reads are indexed,
// pushes beyond DEPTH are dropped and the full flag is registered.
module epg_word_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        push,
    input  logic        clear,
    input  logic [31:0] din,
    input  logic [8:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic [8:0]  count,
    output logic        full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          do_push;

    assign do_push = en && push && !full && !clear;
    assign wr_addr = count[AW-1:0];
    assign rd_addr = rd_idx[AW-1:0];
    assign rd_data = (rd_idx < DEPTH_W) ? mem[rd_addr] : 32'h0;

    // Count and full flag advance together so full is valid the cycle after a push
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            full  <= 1'b0;
        end else if (en) begin
            if (clear) begin
                count <= '0;
                full  <= 1'b0;
            end else if (push && !full) begin
                count <= count + 9'd1;
                full  <= ((count + 9'd1) == DEPTH_W);
            end
        end
    end

    // Storage has no reset; only words below count are ever read out
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

endmodule

// File: rtl/epg_tx_lanes.sv
// IPv4-style packet transmitter: loads header fields, options and payload,
// then serialises the packet MSB-first on a LANES-wide bus with framing strobes.
// Optional header checksum is enabled by defining EPG_CHECKSUM_EN.
module epg_tx_lanes
    import epg_pkg::*;
#(
    parameter int          LANES      = 1,
    parameter int          OPT_DEPTH  = 4,
    parameter int          DATA_DEPTH = 8,
    parameter logic [7:0]  PROTO      = 8'h11,
    parameter int          GAP_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [31:0]      DIN,
    input  logic [2:0]       CTRL,
    input  logic             SEND,
    output logic             BUSY,
    output logic             OFULL,
    output logic             DFULL,
    output logic [LANES-1:0] OP_TX,
    output logic             OP_VALID,
    output logic             OP_SOP,
    output logic             OP_EOP,
    output logic [31:0]      INDICATOR
);

    localparam int         BEATS     = 32 / LANES;
    localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);
    localparam logic [5:0] LANES_W   = 6'(LANES);
    localparam logic [3:0] GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit         NO_GAP    = (GAP_CYCLES == 0);

    state_e      state;
    state_e      next_sec;
    ctrl_e       ctrl_sel;
    logic [7:0]  tos_reg, ttl_reg;
    logic [15:0] id_reg;
    logic [31:0] sa_reg, da_reg;
    logic [8:0]  word_idx;
    logic [5:0]  beat_idx;
    logic [3:0]  gap_cnt;
    logic [8:0]  opt_cnt, data_cnt, opt_rd_idx;
    logic [31:0] opt_rd, data_rd, cur_word, shifted;
    logic [3:0]  ihl;
    logic [10:0] words_total;
    logic [15:0] total_len, cksum;
    logic        load_ok, push_opt, push_data, in_tx, last_beat, sec_last, pkt_last;
    logic        eop_now, pkt_done, clear_bufs, calc_done;

    assign ctrl_sel    = ctrl_e'(CTRL);
    assign load_ok     = EN && (state == S_IDLE);
    assign push_opt    = load_ok && (ctrl_sel == OPT);
    assign push_data   = load_ok && (ctrl_sel == DTA);
    assign ihl         = MIN_IHL + opt_cnt[3:0];
    assign words_total = {7'd0, ihl} + {2'd0, data_cnt};
    assign total_len   = {3'd0, words_total, 2'b00};

`ifdef EPG_CHECKSUM_EN
    logic [3:0]  calc_idx;
    logic [15:0] csum_acc, csum_fixed, csum_next;

    assign calc_done  = ({5'd0, calc_idx} == opt_cnt);
    assign opt_rd_idx = (state == S_CALC) ? {5'd0, calc_idx - 4'd1} : word_idx;
    assign cksum      = ~csum_acc;

    // Ones'-complement sum: fixed header halves first, then one option word per cycle
    always_comb begin
        csum_fixed = oc_add16({IPV4_VER, ihl, tos_reg}, total_len);
        csum_fixed = oc_add16(csum_fixed, id_reg);
        csum_fixed = oc_add16(csum_fixed, {ttl_reg, PROTO});
        csum_fixed = oc_add16(csum_fixed, sa_reg[31:16]);
        csum_fixed = oc_add16(csum_fixed, sa_reg[15:0]);
        csum_fixed = oc_add16(csum_fixed, da_reg[31:16]);
        csum_fixed = oc_add16(csum_fixed, da_reg[15:0]);
        csum_next  = (calc_idx == 4'd0) ? csum_fixed
                   : oc_add16(oc_add16(csum_acc, opt_rd[31:16]), opt_rd[15:0]);
    end

    // Accumulate across the CALC cycles; the result is held for the HDR phase
    always_ff @(posedge CLK) begin
        if (RST) begin
            calc_idx <= 4'd0;
            csum_acc <= 16'h0000;
        end else if (EN) begin
            if (state == S_IDLE) begin
                calc_idx <= 4'd0;
            end else if (state == S_CALC) begin
                csum_acc <= csum_next;
                if (!calc_done) calc_idx <= calc_idx + 4'd1;
            end
        end
    end
`else
    assign calc_done  = 1'b1;
    assign opt_rd_idx = word_idx;
    assign cksum      = 16'h0000;
`endif

    epg_word_buf #(.DEPTH(OPT_DEPTH)) u_opt_buf (
        .clk(CLK), .rst(RST), .en(EN), .push(push_opt), .clear(clear_bufs),
        .din(DIN), .rd_idx(opt_rd_idx), .rd_data(opt_rd), .count(opt_cnt), .full(OFULL)
    );

    epg_word_buf #(.DEPTH(DATA_DEPTH)) u_data_buf (
        .clk(CLK), .rst(RST), .en(EN), .push(push_data), .clear(clear_bufs),
        .din(DIN), .rd_idx(word_idx), .rd_data(data_rd), .count(data_cnt), .full(DFULL)
    );

    // Word being shifted out and the section-boundary decisions for the current beat
    always_comb begin
        cur_word = 32'h0;
        sec_last = 1'b0;
        pkt_last = 1'b0;
        next_sec = NO_GAP ? S_IDLE : S_GAP;
        case (state)
            S_HDR: begin
                case (word_idx)
                    9'd0:    cur_word = {IPV4_VER, ihl, tos_reg, total_len};
                    9'd1:    cur_word = {id_reg, 16'h0000};
                    9'd2:    cur_word = {ttl_reg, PROTO, cksum};
                    9'd3:    cur_word = sa_reg;
                    default: cur_word = da_reg;
                endcase
                sec_last = (word_idx == 9'd4);
                pkt_last = sec_last && (opt_cnt == 9'd0) && (data_cnt == 9'd0);
                if (opt_cnt != 9'd0)       next_sec = S_OPT;
                else if (data_cnt != 9'd0) next_sec = S_DATA;
            end
            S_OPT: begin
                cur_word = opt_rd;
                sec_last = (word_idx == opt_cnt - 9'd1);
                pkt_last = sec_last && (data_cnt == 9'd0);
                if (data_cnt != 9'd0) next_sec = S_DATA;
            end
            S_DATA: begin
                cur_word = data_rd;
                sec_last = (word_idx == data_cnt - 9'd1);
                pkt_last = sec_last;
            end
            default: ;
        endcase
    end

    assign in_tx      = state inside {S_HDR, S_OPT, S_DATA};
    assign last_beat  = (beat_idx == LAST_BEAT);
    assign eop_now    = in_tx && last_beat && pkt_last;
    assign pkt_done   = ((state == S_GAP) && (gap_cnt == GAP_LAST)) || (NO_GAP && eop_now);
    assign clear_bufs = EN && pkt_done;
    assign shifted    = cur_word << (beat_idx * LANES_W);

    assign BUSY      = (state != S_IDLE);
    assign OP_TX     = in_tx ? shifted[31 -: LANES] : '0;
    assign OP_VALID  = EN && in_tx;
    assign OP_SOP    = EN && (state == S_HDR) && (word_idx == 9'd0) && (beat_idx == 6'd0);
    assign OP_EOP    = EN && eop_now;
    assign INDICATOR = {12'd0, ihl, total_len};

    // Header field loads, accepted only while idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            tos_reg <= 8'h00;
            ttl_reg <= 8'h00;
            id_reg  <= 16'h0000;
            sa_reg  <= 32'h0;
            da_reg  <= 32'h0;
        end else if (load_ok) begin
            case (ctrl_sel)
                TOS:     tos_reg <= DIN[7:0];
                ID:      id_reg  <= DIN[15:0];
                TTL:     ttl_reg <= DIN[7:0];
                SA:      sa_reg  <= DIN;
                DA:      da_reg  <= DIN;
                default: ;
            endcase
        end
    end

    // Packet sequencer: beat and word counters walk HDR, OPT and DATA, then the gap
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            word_idx <= 9'd0;
            beat_idx <= 6'd0;
            gap_cnt  <= 4'd0;
        end else if (EN) begin
            case (state)
                S_IDLE: begin
                    if (SEND) begin
                        word_idx <= 9'd0;
                        beat_idx <= 6'd0;
                        gap_cnt  <= 4'd0;
`ifdef EPG_CHECKSUM_EN
                        state    <= S_CALC;
`else
                        state    <= S_HDR;
`endif
                    end
                end
                S_CALC: begin
                    if (calc_done) state <= S_HDR;
                end
                S_HDR, S_OPT, S_DATA: begin
                    if (last_beat) begin
                        beat_idx <= 6'd0;
                        if (sec_last) begin
                            word_idx <= 9'd0;
                            state    <= next_sec;
                        end else begin
                            word_idx <= word_idx + 9'd1;
                        end
                    end else begin
                        beat_idx <= beat_idx + 6'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= S_IDLE;
                    else                     gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
